hazard_ctrl: RTL

- Central hazard/sequencing controller for the 5-stage pipeline.
- Drives the stall and flush inputs of the IF/ID register, the PC enable, the ID/EX bubble insert and the EX/MEM hold.
- Resolves three hazards:
  - load-use data hazard (one bubble);
  - taken-branch control hazard (squash IF/ID and ID/EX);
  - multi-cycle data-memory wait (freeze the whole front end), with a watchdog.

---
 rtl/hazard_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Central hazard/sequencing controller for the 5-stage pipeline. It resolves:
//   - load-use data hazards (one ID/EX bubble, PC and IF/ID held),
//   - taken-branch control hazards (IF/ID and ID/EX squashed),
//   - multi-cycle data-memory waits (front end frozen), with a sticky watchdog.
//
// Parameters:
//   WAIT_TIMEOUT  max consecutive mem_busy cycles before err_timeout sets
//   TO_W          wait counter width, 2**TO_W > WAIT_TIMEOUT
//   CNT_W         performance counter width (optional feature only)
//
// Ports:
//   clk, rst                  clock (posedge), async active-high reset
//   id_rs1/id_rs2             source registers of the ID instruction
//   id_use_rs1/id_use_rs2     ID instruction actually reads that source
//   ex_rd, ex_mem_read        destination / is-load of the EX instruction
//   br_taken                  EX resolved a taken branch or jump
//   mem_busy                  data memory not ready, MEM must hold
//   pc_stall, if_id_stall     hold PC / IF/ID
//   if_id_flush, id_ex_flush  squash IF/ID / insert ID/EX bubble
//   ex_mem_stall              hold EX/MEM and everything upstream
//   err_timeout               sticky watchdog error
//   state                     current FSM state (debug)
//
// Optional feature (macro HAZARD_PERF_CNT_EN): saturating counters
//   lu_stall_cnt, mem_stall_cnt, flush_cnt.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned TO_W         = 7,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             err_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MEM_WAIT  = 2'd2
    } state_e;

    localparam logic [TO_W-1:0] TIMEOUT = TO_W'(WAIT_TIMEOUT);

    state_e          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            br_pend_q, br_pend_d;
    logic            err_q, err_d;

    logic lu;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_flush_c, ex_mem_stall_c;

    // x0 is never a real dependency, so a load to x0 cannot cause a stall.
    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        br_pend_d      = br_pend_q;
        err_d          = err_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_stall_c = 1'b0;

        case (state_q)
            MEM_WAIT: begin
                if (mem_busy) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    // A branch resolved while frozen is remembered and
                    // applied on the exit cycle.
                    br_pend_d      = br_pend_q | br_taken;
                    if (wait_cnt_q < TIMEOUT) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    // Exit cycle: lu is deliberately not evaluated here.
                    if (br_pend_q || br_taken) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end
                    br_pend_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = RUN;
                end
            end
            // RUN, LU_BUBBLE and the unused encoding share one path; the
            // bubble differs only in ignoring lu.
            default: begin
                state_d = RUN;
                if (mem_busy) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                    br_pend_d      = br_taken;
                    wait_cnt_d     = TO_W'(1);
                    state_d        = MEM_WAIT;
                end else if (br_taken) begin
                    // The ID instruction is squashed, so a matching lu is moot.
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (lu && (state_q != LU_BUBBLE)) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    state_d       = LU_BUBBLE;
                end
            end
        endcase

        if (wait_cnt_d >= TIMEOUT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            br_pend_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            br_pend_q  <= br_pend_d;
            err_q      <= err_d;
        end
    end

    // Control outputs are forced low for the whole time reset is held.
    assign pc_stall     = pc_stall_c     & ~rst;
    assign if_id_stall  = if_id_stall_c  & ~rst;
    assign if_id_flush  = if_id_flush_c  & ~rst;
    assign id_ex_flush  = id_ex_flush_c  & ~rst;
    assign ex_mem_stall = ex_mem_stall_c & ~rst;
    assign err_timeout  = err_q;
    assign state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt_q, mem_cnt_q, flush_cnt_q;
    logic             lu_enter;

    assign lu_enter = (state_q != LU_BUBBLE) && (state_q != MEM_WAIT) &&
                      (state_d == LU_BUBBLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q    <= '0;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (lu_enter && (lu_cnt_q != '1)) begin
                lu_cnt_q <= lu_cnt_q + 1'b1;
            end
            if (ex_mem_stall_c && (mem_cnt_q != '1)) begin
                mem_cnt_q <= mem_cnt_q + 1'b1;
            end
            if (if_id_flush_c && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign lu_stall_cnt  = lu_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;
    assign flush_cnt     = flush_cnt_q;
`endif

endmodule
